// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: steps the shared PC/IR/RF/ALU/DM datapath one state per clock.
// Controls are registered alongside the state; only BR's pc_we (zero) and reset gating are combinational.
module mips_mc_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic       dm_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic [1:0] pc_src,
    output logic [3:0] state_o,
    output logic       halted
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,  S_DCD  = 4'd1,  S_MA    = 4'd2,  S_MR   = 4'd3,
        S_WB_LD = 4'd4,  S_MW   = 4'd5,  S_EXE_R = 4'd6,  S_WB_R = 4'd7,
        S_EXE_I = 4'd8,  S_WB_I = 4'd9,  S_BR    = 4'd10, S_JMP  = 4'd11,
        S_JAL   = 4'd12, S_JR   = 4'd13, S_HALT  = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       dm_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    state_t w_bad_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl;

    // Control word for a state; BR's pc_we is left 0 here and qualified by zero at the output.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] opc, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_we = 1'b1;  c.pc_we = 1'b1;  c.alu_src_b = 2'd1;
            end
            S_DCD: begin
                c.alu_src_b = 2'd3;  c.ext_op = 1'b1;
            end
            S_MA: begin
                c.alu_src_a = 1'b1;  c.alu_src_b = 2'd2;  c.ext_op = 1'b1;
            end
            S_WB_LD: begin
                c.rf_we = 1'b1;  c.mem_to_reg = 2'd1;
            end
            S_MW:    c.dm_we = 1'b1;
            S_EXE_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = (fn == FN_SUBU) ? 2'd1 : 2'd0;
            end
            S_WB_R: begin
                c.rf_we = 1'b1;  c.reg_dst = 2'd1;
            end
            S_EXE_I: begin
                c.alu_src_a = 1'b1;  c.alu_src_b = 2'd2;
                c.alu_op    = (opc == OP_LUI) ? 2'd3 : 2'd2;
            end
            S_WB_I:  c.rf_we = 1'b1;
            S_BR: begin
                c.alu_src_a = 1'b1;  c.alu_op = 2'd1;  c.pc_src = 2'd1;
            end
            S_JMP: begin
                c.pc_we = 1'b1;  c.pc_src = 2'd2;
            end
            S_JAL: begin
                c.pc_we = 1'b1;  c.pc_src = 2'd2;  c.rf_we = 1'b1;
                c.reg_dst = 2'd2;  c.mem_to_reg = 2'd2;
            end
            S_JR: begin
                c.pc_we = 1'b1;  c.pc_src = 2'd3;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_bad_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;

    // Next-state decode; op/funct are stable from DCD to the end of the instruction.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DCD;
            S_DCD: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_ADDU || funct == FN_SUBU) w_next = S_EXE_R;
                        else if (funct == FN_JR)                  w_next = S_JR;
                        else                                      w_next = w_bad_next;
                    end
                    OP_ORI, OP_LUI: w_next = S_EXE_I;
                    OP_LW, OP_SW:   w_next = S_MA;
                    OP_BEQ:         w_next = S_BR;
                    OP_J:           w_next = S_JMP;
                    OP_JAL:         w_next = S_JAL;
                    default:        w_next = w_bad_next;
                endcase
            end
            S_MA:    w_next = (op == OP_LW) ? S_MR : S_MW;
            S_MR:    w_next = S_WB_LD;
            S_EXE_R: w_next = S_WB_R;
            S_EXE_I: w_next = S_WB_I;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = ctrl_for(w_next, op, funct);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH, op, funct);
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
        end
    end

    // Write enables and halted are held low for as long as reset is asserted.
    assign pc_we      = ~rst & (r_ctrl.pc_we | ((r_state == S_BR) & zero));
    assign ir_we      = ~rst & r_ctrl.ir_we;
    assign rf_we      = ~rst & r_ctrl.rf_we;
    assign dm_we      = ~rst & r_ctrl.dm_we;
    assign halted     = ~rst & r_ctrl.halted;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_op     = r_ctrl.alu_op;
    assign ext_op     = r_ctrl.ext_op;
    assign pc_src     = r_ctrl.pc_src;
    assign state_o    = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: one instance per ILLEGAL_TRAP setting, driven in lockstep.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, ir_we, rf_we, dm_we;
        logic [1:0] reg_dst, m2r;
        logic       a;
        logic [1:0] b, aop;
        logic       ext;
        logic [1:0] psrc;
        logic       halted;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } item_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ORI = 6'b001101;
    localparam logic [5:0] LUI = 6'b001111, BEQ = 6'b000100, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       pc_we0, ir_we0, rf_we0, dm_we0, a0, ext0, halted0;
    logic [1:0] reg_dst0, m2r0, b0, aop0, psrc0;
    logic [3:0] st0;
    logic       pc_we1, ir_we1, rf_we1, dm_we1, a1, ext1, halted1;
    logic [1:0] reg_dst1, m2r1, b1, aop1, psrc1;
    logic [3:0] st1;

    item_t q0[$];
    item_t q1[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    string cur_tag = "reset";

    mips_mc_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we0), .ir_we(ir_we0), .rf_we(rf_we0), .dm_we(dm_we0),
        .reg_dst(reg_dst0), .mem_to_reg(m2r0), .alu_src_a(a0), .alu_src_b(b0),
        .alu_op(aop0), .ext_op(ext0), .pc_src(psrc0), .state_o(st0), .halted(halted0)
    );

    mips_mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we1), .ir_we(ir_we1), .rf_we(rf_we1), .dm_we(dm_we1),
        .reg_dst(reg_dst1), .mem_to_reg(m2r1), .alu_src_a(a1), .alu_src_b(b1),
        .alu_op(aop1), .ext_op(ext1), .pc_src(psrc1), .state_o(st1), .halted(halted1)
    );

    always #5 clk = ~clk;

    // Expected outputs for a state, from the state table plus the funct/op/zero dependent fields.
    function automatic exp_t expv(input logic [3:0] s, input logic r, input logic [5:0] o,
                                  input logic [5:0] f, input logic z);
        exp_t e;
        e = '0;
        e.st = s;
        case (s)
            4'd0:  begin e.pc_we = 1; e.ir_we = 1; e.b = 2'd1; end
            4'd1:  begin e.b = 2'd3; e.ext = 1; end
            4'd2:  begin e.a = 1; e.b = 2'd2; e.ext = 1; end
            4'd4:  begin e.rf_we = 1; e.m2r = 2'd1; end
            4'd5:  e.dm_we = 1;
            4'd6:  begin e.a = 1; e.aop = (f == 6'b100011) ? 2'd1 : 2'd0; end
            4'd7:  begin e.rf_we = 1; e.reg_dst = 2'd1; end
            4'd8:  begin e.a = 1; e.b = 2'd2; e.aop = (o == LUI) ? 2'd3 : 2'd2; end
            4'd9:  e.rf_we = 1;
            4'd10: begin e.a = 1; e.aop = 2'd1; e.psrc = 2'd1; e.pc_we = z; end
            4'd11: begin e.pc_we = 1; e.psrc = 2'd2; end
            4'd12: begin e.pc_we = 1; e.psrc = 2'd2; e.rf_we = 1; e.reg_dst = 2'd2; e.m2r = 2'd2; end
            4'd13: begin e.pc_we = 1; e.psrc = 2'd3; end
            4'd14: e.halted = 1;
            default: e = e;
        endcase
        if (r) begin
            e.pc_we = 0; e.ir_we = 0; e.rf_we = 0; e.dm_we = 0; e.halted = 0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic [3:0] s0, input logic [3:0] s1);
        item_t it;
        @(negedge clk);
        rst = r; op = o; funct = f; zero = z;
        it.tag = cur_tag;
        it.e = expv(s0, r, o, f, z);
        q0.push_back(it);
        it.e = expv(s1, r, o, f, z);
        q1.push_back(it);
    endtask

    // One instruction, both DUTs on the same path; states are nibbles of sts, first state leftmost.
    task automatic seq(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [19:0] sts, input int n);
        logic [3:0] s;
        cur_tag = tag;
        for (int i = 0; i < n; i++) begin
            s = sts[4*(n-1-i) +: 4];
            step(1'b0, o, f, z, s, s);
        end
    endtask

    // Monitor: every cycle the DUTs present a control word, compare it with the queued expectation.
    initial begin
        item_t it;
        exp_t  act;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (q0.size() != 0) begin
                it  = q0.pop_front();
                act = {st0, pc_we0, ir_we0, rf_we0, dm_we0, reg_dst0, m2r0, a0, b0, aop0, ext0, psrc0, halted0};
                n_tests++;
                if (act !== it.e) begin
                    n_fail++;
                    $display("FAIL %s trap0 cyc=%0d got %h required %h", it.tag, cyc, act, it.e);
                end
            end
            if (q1.size() != 0) begin
                it  = q1.pop_front();
                act = {st1, pc_we1, ir_we1, rf_we1, dm_we1, reg_dst1, m2r1, a1, b1, aop1, ext1, psrc1, halted1};
                n_tests++;
                if (act !== it.e) begin
                    n_fail++;
                    $display("FAIL %s trap1 cyc=%0d got %h required %h", it.tag, cyc, act, it.e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        cur_tag = "reset";
        step(1'b1, 6'd0, 6'd0, 1'b0, 4'd0, 4'd0);

        seq("lw",        LW,  6'd0,      1'b0, 20'h01234, 5);
        seq("sw",        SW,  6'd0,      1'b0, 20'h00125, 4);
        seq("addu",      RT,  6'b100001, 1'b0, 20'h00167, 4);
        seq("subu",      RT,  6'b100011, 1'b1, 20'h00167, 4);
        seq("ori",       ORI, 6'd0,      1'b0, 20'h00189, 4);
        seq("lui",       LUI, 6'd0,      1'b0, 20'h00189, 4);
        seq("beq_taken", BEQ, 6'd0,      1'b1, 20'h0001A, 3);
        seq("beq_not",   BEQ, 6'd0,      1'b0, 20'h0001A, 3);
        seq("j",         J,   6'd0,      1'b0, 20'h0001B, 3);
        seq("jal",       JAL, 6'd0,      1'b0, 20'h0001C, 3);
        seq("jr",        RT,  6'b001000, 1'b0, 20'h0001D, 3);

        seq("rst_mr", LW, 6'd0, 1'b0, 20'h00012, 3);
        step(1'b1, LW, 6'd0, 1'b0, 4'd3, 4'd3);
        seq("rst_mr_rec", LW, 6'd0, 1'b0, 20'h01234, 5);
        seq("rst_mw", SW, 6'd0, 1'b0, 20'h00012, 3);
        step(1'b1, SW, 6'd0, 1'b0, 4'd5, 4'd5);
        seq("rst_mw_rec", SW, 6'd0, 1'b0, 20'h00125, 4);

        cur_tag = "illegal";
        step(1'b0, BAD, 6'd0, 1'b0, 4'd0, 4'd0);
        step(1'b0, BAD, 6'd0, 1'b0, 4'd1, 4'd1);
        step(1'b0, BAD, 6'd0, 1'b0, 4'd0, 4'd14);
        cur_tag = "halt_hold";
        for (int i = 0; i < 10; i++)
            step(1'b0, BAD, 6'd0, 1'b0, (i % 2 == 0) ? 4'd1 : 4'd0, 4'd14);
        cur_tag = "halt_rst";
        step(1'b1, BAD, 6'd0, 1'b0, 4'd1, 4'd14);
        seq("after_halt", J, 6'd0, 1'b0, 20'h0001B, 3);
        cur_tag = "bad_funct";
        step(1'b0, RT, 6'b100000, 1'b0, 4'd0, 4'd0);
        step(1'b0, RT, 6'b100000, 1'b0, 4'd1, 4'd1);
        step(1'b0, RT, 6'b100000, 1'b0, 4'd0, 4'd14);

        @(negedge clk);
        #4;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain q0=%0d q1=%0d left, required 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
